// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param. With FIFO_ERR_CNT_EN it also carries the saturating error counters.
// Latency and backpressure: none here, wires only; the FIFO answers every request with a one-cycle ack or err.
// master = producer/consumer side, slave = FIFO side.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  wr_ack;
    logic                  wr_err;
    logic                  rd_ack;
    logic                  rd_err;
`ifdef FIFO_ERR_CNT_EN
    logic [7:0]            wr_err_cnt;
    logic [7:0]            rd_err_cnt;

    modport master (
        output wr_en, din, rd_en,
        input  dout, data_count, full, empty, almost_full, almost_empty,
        input  wr_ack, wr_err, rd_ack, rd_err, wr_err_cnt, rd_err_cnt
    );
    modport slave (
        input  wr_en, din, rd_en,
        output dout, data_count, full, empty, almost_full, almost_empty,
        output wr_ack, wr_err, rd_ack, rd_err, wr_err_cnt, rd_err_cnt
    );
`else
    modport master (
        output wr_en, din, rd_en,
        input  dout, data_count, full, empty, almost_full, almost_empty,
        input  wr_ack, wr_err, rd_ack, rd_err
    );
    modport slave (
        input  wr_en, din, rd_en,
        output dout, data_count, full, empty, almost_full, almost_empty,
        output wr_ack, wr_err, rd_ack, rd_err
    );
`endif
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with a state register, level flags and ack/err pulses. FIFO_ERR_CNT_EN adds error counters.
// Latency: a request sampled at one edge updates pointers, count, dout and ack/err at that same edge.
// Backpressure: writes when full and reads when empty are rejected with a one-cycle err; rd+wr on full is accepted.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_TH   = 7,
    parameter int AEMPTY_TH  = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    fifo_sync_param_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] L_DEPTH  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] L_AFULL  = AFULL_TH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] L_AEMPTY = AEMPTY_TH[ADDR_WIDTH:0];

    typedef enum logic [2:0] {
        S_INIT,
        S_NO_OP,
        S_WRITE,
        S_WR_ERROR,
        S_READ,
        S_RD_ERROR,
        S_RDWR
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_head;
    logic [ADDR_WIDTH-1:0] r_tail;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_rd_rejected;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_go;
    logic                  w_rd_go;

    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == '0);

    always_comb begin
        w_next_state = S_NO_OP;
        unique case ({bus.wr_en, bus.rd_en})
            2'b10:   w_next_state = w_full  ? S_WR_ERROR : S_WRITE;
            2'b01:   w_next_state = w_empty ? S_RD_ERROR : S_READ;
            2'b11:   w_next_state = S_RDWR;
            default: w_next_state = S_NO_OP;
        endcase
    end

    // RDWR on a full FIFO still frees a slot for the write; RDWR on empty loses only the read.
    assign w_wr_go = (w_next_state == S_WRITE) || (w_next_state == S_RDWR);
    assign w_rd_go = (w_next_state == S_READ) || ((w_next_state == S_RDWR) && !w_empty);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_INIT;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_dout        <= '0;
            r_rd_rejected <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_rd_rejected <= (w_next_state == S_RDWR) && w_empty;
            if (w_wr_go) begin
                r_head <= r_head + 1'b1;
            end
            if (w_rd_go) begin
                r_tail <= r_tail + 1'b1;
                r_dout <= r_mem[r_tail];
            end
            unique case ({w_wr_go, w_rd_go})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; a read on the same edge sees the old word.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_wr_go) begin
            r_mem[r_head] <= bus.din;
        end
    end

`ifdef FIFO_ERR_CNT_EN
    logic [7:0] r_wr_err_cnt;
    logic [7:0] r_rd_err_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_err_cnt <= '0;
            r_rd_err_cnt <= '0;
        end else begin
            if ((w_next_state == S_WR_ERROR) && (r_wr_err_cnt != 8'hFF)) begin
                r_wr_err_cnt <= r_wr_err_cnt + 1'b1;
            end
            if (bus.rd_en && !w_rd_go && (r_rd_err_cnt != 8'hFF)) begin
                r_rd_err_cnt <= r_rd_err_cnt + 1'b1;
            end
        end
    end

    assign bus.wr_err_cnt = r_wr_err_cnt;
    assign bus.rd_err_cnt = r_rd_err_cnt;
`endif

    assign bus.dout         = r_dout;
    assign bus.data_count   = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= L_AFULL);
    assign bus.almost_empty = (r_count <= L_AEMPTY);

    // Acks/errs are decodes of the state register, so each lasts exactly the cycle after the request.
    assign bus.wr_ack = (r_state == S_WRITE) || (r_state == S_RDWR);
    assign bus.wr_err = (r_state == S_WR_ERROR);
    assign bus.rd_ack = (r_state == S_READ) || ((r_state == S_RDWR) && !r_rd_rejected);
    assign bus.rd_err = (r_state == S_RD_ERROR) || ((r_state == S_RDWR) && r_rd_rejected);
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: queue-based reference model compared every cycle plus literal spot checks.
module tb_fifo_sync_param;
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_sync_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(7), .AEMPTY_TH(1)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: a queue; a read pops before a write pushes within one request.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_wa, m_we, m_ra, m_re;
    int            m_wec, m_rec;
    bit            started = 0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_dout = '0;
            m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
            m_wec = 0; m_rec = 0;
        end else begin
            m_wa = 0; m_we = 0; m_ra = 0; m_re = 0;
            if (bus.rd_en) begin
                if (q.size() > 0) begin
                    m_dout = q.pop_front();
                    m_ra = 1;
                end else begin
                    m_re = 1;
                end
            end
            if (bus.wr_en) begin
                if (q.size() < DEPTH) begin
                    q.push_back(bus.din);
                    m_wa = 1;
                end else begin
                    m_we = 1;
                end
            end
            if (m_we && m_wec < 255) m_wec++;
            if (m_re && m_rec < 255) m_rec++;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            int n;
            logic [43:0] exp_v, act_v;
            n = q.size();
            exp_v = {m_dout, 4'(n), (n == DEPTH), (n == 0), (n >= 7), (n <= 1),
                     m_wa, m_we, m_ra, m_re};
            act_v = {bus.dout, bus.data_count, bus.full, bus.empty, bus.almost_full,
                     bus.almost_empty, bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err};
            chk("model_cycle", 64'(act_v), 64'(exp_v));
`ifdef FIFO_ERR_CNT_EN
            chk("model_errcnt", 64'({bus.wr_err_cnt, bus.rd_err_cnt}),
                64'({8'(m_wec), 8'(m_rec)}));
`endif
        end
    end

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        bus.wr_en = w;
        bus.din   = d;
        bus.rd_en = r;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        bus.din   = '0;
        bus.rd_en = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_full", 64'(bus.full), 64'd0);
        chk("rst_aempty", 64'(bus.almost_empty), 64'd1);
        chk("rst_count", 64'(bus.data_count), 64'd0);
        chk("rst_dout", 64'(bus.dout), 64'd0);
        chk("rst_ackerr", 64'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}), 64'd0);
        reset = 1'b0;
        step(0, 0, 0);

        // Fill 0x11..0x88, then overflow once.
        for (int i = 1; i <= 8; i++) begin
            step(1, DW'(i * 17), 0);
            if (i == 6) chk("afull_at6", 64'(bus.almost_full), 64'd0);
            if (i == 7) chk("afull_at7", 64'(bus.almost_full), 64'd1);
        end
        chk("fill_count", 64'(bus.data_count), 64'd8);
        chk("fill_full", 64'(bus.full), 64'd1);
        step(1, 32'h99, 0);
        chk("ovf_wr_err", 64'(bus.wr_err), 64'd1);
        chk("ovf_count", 64'(bus.data_count), 64'd8);
        step(0, 0, 0);
        chk("ovf_err_pulse", 64'(bus.wr_err), 64'd0);

        // Drain in order, then underflow once.
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1);
            chk("drain_dout", 64'(bus.dout), 64'(i * 17));
            chk("drain_ack", 64'(bus.rd_ack), 64'd1);
        end
        chk("drain_empty", 64'(bus.empty), 64'd1);
        step(0, 0, 1);
        chk("udf_rd_err", 64'(bus.rd_err), 64'd1);
        chk("udf_dout_hold", 64'(bus.dout), 64'h88);
        step(0, 0, 0);

        // Pointer wrap.
        for (int i = 0; i < 5; i++) step(1, DW'(32'h50 + i), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, DW'(32'hA0 + i), 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1);
            chk("wrap_dout", 64'(bus.dout), 64'(32'hA0 + i));
        end
        chk("wrap_count", 64'(bus.data_count), 64'd0);

        // Simultaneous read/write: mid-level, full, empty.
        for (int i = 1; i <= 3; i++) step(1, DW'(32'hC0 + i), 0);
        step(1, 32'hC4, 1);
        chk("rdwr3_count", 64'(bus.data_count), 64'd3);
        chk("rdwr3_dout", 64'(bus.dout), 64'hC1);
        for (int i = 0; i < 5; i++) step(1, DW'(32'hD0 + i), 0);
        chk("pre_full", 64'(bus.full), 64'd1);
        step(1, 32'hE0, 1);
        chk("rdwr_full_dout", 64'(bus.dout), 64'hC2);
        chk("rdwr_full_count", 64'(bus.data_count), 64'd8);
        chk("rdwr_full_acks", 64'({bus.wr_ack, bus.rd_ack}), 64'b11);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        chk("drain2_last", 64'(bus.dout), 64'hE0);
        step(1, 32'hF0, 1);
        chk("rdwr_empty_ackerr", 64'({bus.wr_ack, bus.rd_err, bus.rd_ack}), 64'b110);
        chk("rdwr_empty_count", 64'(bus.data_count), 64'd1);
        chk("rdwr_empty_dout", 64'(bus.dout), 64'hE0);

        // Reset mid-operation with a write pending.
        for (int i = 1; i <= 3; i++) step(1, DW'(32'hB0 + i), 0);
        chk("pre_rst_count", 64'(bus.data_count), 64'd4);
        reset = 1'b1;
        step(1, 32'hEE, 0);
        chk("midrst_count", 64'(bus.data_count), 64'd0);
        chk("midrst_empty", 64'(bus.empty), 64'd1);
        chk("midrst_wr_ack", 64'(bus.wr_ack), 64'd0);
        reset = 1'b0;
        step(0, 0, 0);

`ifdef FIFO_ERR_CNT_EN
        for (int i = 0; i < 8; i++) step(1, DW'(i), 0);
        for (int i = 0; i < 3; i++) step(1, 32'hFF, 0);
        chk("wr_err_cnt", 64'(bus.wr_err_cnt), 64'd3);
        step(0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
